sr_latch_ctrl: RTL

Sequencer and arbiter that shares one level-enabled SR latch (clk/s/r/q/qbar style) between NREQ requesters. Each requester asks to set or clear the shared flag. The block grants one request at a time in round-robin order. It drives s/r with setup and hold margins around the latch enable, so s=r=1 is never presented. After each write it reads q back and checks it, then acknowledges the requester.

---
 rtl/sr_latch_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sr_latch_ctrl.sv
// Round-robin arbiter and sequencer that shares one level-enabled SR latch between NREQ requesters.
// Each write goes through setup, enable pulse, hold and q readback before the requester is acked.

module sr_lane (
    input  logic set,
    input  logic clr,
    output logic elig,
    output logic conflict
);
    assign elig     = set ^ clr;
    assign conflict = set & clr;
endmodule

module sr_latch_ctrl #(
    parameter int NREQ    = 4,
    parameter int PULSE_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_set,
    input  logic [NREQ-1:0] req_clr,
    output logic [NREQ-1:0] ack,
    output logic            busy,
    output logic            lat_en,
    output logic            lat_s,
    output logic            lat_r,
    input  logic            lat_q,
    output logic            flag_o,
    output logic            fault_o,
    output logic            err_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   rr_ptr, rr_ptr_nx, gnt_id, gnt_id_nx, win;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            op, op_nx, found;
    logic [NREQ-1:0] elig, conflict, cand, ack_nx;
    logic            busy_nx, lat_en_nx, lat_s_nx, lat_r_nx;
    logic            flag_nx, fault_nx, err_nx;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        sr_lane u_lane (
            .set      (req_set[i]),
            .clr      (req_clr[i]),
            .elig     (elig[i]),
            .conflict (conflict[i])
        );
    end

    // The requester acked this cycle still holds its request; keep it out of arbitration.
    assign cand = elig & ~ack;

    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        rr_ptr_nx = rr_ptr;
        gnt_id_nx = gnt_id;
        op_nx     = op;
        cnt_nx    = cnt;
        ack_nx    = '0;
        flag_nx   = flag_o;
        fault_nx  = fault_o;
        err_nx    = err_o | (|conflict);
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx  = SETUP;
                    gnt_id_nx = win;
                    op_nx     = req_set[win];
                    rr_ptr_nx = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
                end
            end
            SETUP: begin
                state_nx = PULSE;
                cnt_nx   = CW'(PULSE_W-1);
            end
            PULSE: begin
                if (cnt == '0) state_nx = HOLD;
                else           cnt_nx   = cnt - 1'b1;
            end
            HOLD:  state_nx = CHECK;
            CHECK: begin
                state_nx       = IDLE;
                flag_nx        = lat_q;
                fault_nx       = fault_o | (lat_q != op);
                ack_nx[gnt_id] = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // Outputs are decoded from the next state so they register alongside it.
        busy_nx   = (state_nx != IDLE);
        lat_en_nx = (state_nx == PULSE);
        lat_s_nx  = (state_nx inside {SETUP, PULSE, HOLD}) &&  op_nx;
        lat_r_nx  = (state_nx inside {SETUP, PULSE, HOLD}) && !op_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_id  <= '0;
            op      <= 1'b0;
            cnt     <= '0;
            ack     <= '0;
            busy    <= 1'b0;
            lat_en  <= 1'b0;
            lat_s   <= 1'b0;
            lat_r   <= 1'b0;
            flag_o  <= 1'b0;
            fault_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_nx;
            rr_ptr  <= rr_ptr_nx;
            gnt_id  <= gnt_id_nx;
            op      <= op_nx;
            cnt     <= cnt_nx;
            ack     <= ack_nx;
            busy    <= busy_nx;
            lat_en  <= lat_en_nx;
            lat_s   <= lat_s_nx;
            lat_r   <= lat_r_nx;
            flag_o  <= flag_nx;
            fault_o <= fault_nx;
            err_o   <= err_nx;
        end
    end
endmodule
